// File: rtl/uart_rx_packet_checker.sv
// Checks start/stop/parity on frames from the UART receiver, queues good bytes
// in a small first-word-fall-through FIFO and keeps saturating error statistics.
module uart_rx_packet_checker #(
  parameter int DEPTH      = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                     UART_CLK,
  input  logic                     UART_RST,
  input  logic [10:0]              PACKET_IN,
  input  logic                     PACKET_VALID,
  input  logic                     DATA_READY,
  output logic [7:0]               DATA_OUT,
  output logic                     DATA_VALID,
  output logic [$clog2(DEPTH):0]   FIFO_COUNT,
  output logic [7:0]               FRAME_ERR_CNT,
  output logic [7:0]               PARITY_ERR_CNT,
  output logic                     OVERFLOW,
  input  logic                     CLR_STATUS
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          s1_valid;
  logic [10:0]   s1_frame;
  logic [7:0]    s1_data;
  logic          frame_bad;
  logic          parity_bad;
  logic          frame_err;
  logic          par_err;
  logic          good;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          ovf_evt;

  // The frame register only loads on a strobe, so an undriven bus between
  // frames never reaches the checker.
  always_ff @(posedge UART_CLK or posedge UART_RST) begin
    if (UART_RST) begin
      s1_valid <= 1'b0;
      s1_frame <= '0;
    end else begin
      s1_valid <= PACKET_VALID;
      if (PACKET_VALID) begin
        s1_frame <= PACKET_IN;
      end
    end
  end

  // Data arrives LSB first, so the payload is bit-reversed within [9:2].
  always_comb begin
    s1_data = '0;
    for (int i = 0; i < 8; i++) begin
      s1_data[i] = s1_frame[9-i];
    end
  end

  assign frame_bad  = s1_frame[10] | ~s1_frame[0];
  assign parity_bad = s1_frame[1] ^ (^s1_data) ^ PARITY_ODD;
  assign frame_err  = s1_valid & frame_bad;
  assign par_err    = s1_valid & ~frame_bad & parity_bad;
  assign good       = s1_valid & ~frame_bad & ~parity_bad;

  assign full    = (count == CW'(DEPTH));
  assign pop     = DATA_VALID & DATA_READY;
  assign push_ok = good & (~full | pop);
  assign ovf_evt = good & full & ~pop;

  always_ff @(posedge UART_CLK or posedge UART_RST) begin
    if (UART_RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= s1_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign DATA_OUT   = mem[rd_ptr];
  assign DATA_VALID = (count != '0);
  assign FIFO_COUNT = count;

  // A clear takes priority, so an error or overflow in the same cycle is lost.
  always_ff @(posedge UART_CLK or posedge UART_RST) begin
    if (UART_RST) begin
      FRAME_ERR_CNT  <= '0;
      PARITY_ERR_CNT <= '0;
      OVERFLOW       <= 1'b0;
    end else if (CLR_STATUS) begin
      FRAME_ERR_CNT  <= '0;
      PARITY_ERR_CNT <= '0;
      OVERFLOW       <= 1'b0;
    end else begin
      if (frame_err && (FRAME_ERR_CNT != 8'hFF)) begin
        FRAME_ERR_CNT <= FRAME_ERR_CNT + 8'd1;
      end
      if (par_err && (PARITY_ERR_CNT != 8'hFF)) begin
        PARITY_ERR_CNT <= PARITY_ERR_CNT + 8'd1;
      end
      if (ovf_evt) begin
        OVERFLOW <= 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_rx_packet_checker.md
Name: uart_rx_packet_checker

Overview:
- Sits directly downstream of the UART receiver. Consumes its 11-bit captured frame (Packet_In) plus a one-cycle frame-complete strobe.
- Validates start, stop and parity bits and extracts the 8-bit payload.
- Queues good bytes in a small first-word-fall-through (FWFT) FIFO with a valid/ready output.
- Keeps saturating error counters and a sticky overflow flag for the status logic.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- PARITY_ODD, 0, 0: expected parity bit = XOR of data (matches transmitter); 1: inverted.

Ports:
- UART_CLK  input  1  single clock; all logic on posedge.
- UART_RST  input  1  asynchronous, active-high reset.
- PACKET_IN  input  11  received frame.
  - [10] start (expect 0).
  - [9:2] data, with data[0]=PACKET_IN[9] … data[7]=PACKET_IN[2].
  - [1] parity.
  - [0] stop (expect 1).
- PACKET_VALID  input  1  one-cycle strobe: PACKET_IN holds a complete frame.
- DATA_READY  input  1  consumer accepts DATA_OUT this cycle.
- DATA_OUT  output  8  head-of-FIFO byte.
- DATA_VALID  output  1  FIFO non-empty.
- FIFO_COUNT  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- FRAME_ERR_CNT  output  8  saturating count of frame errors.
- PARITY_ERR_CNT  output  8  saturating count of parity errors.
- OVERFLOW  output  1  sticky: good byte dropped because FIFO full.
- CLR_STATUS  input  1  synchronous clear of counters and OVERFLOW.

Behaviour:
- Reset (async assert, sync use after deassert):
  - DATA_OUT=0, DATA_VALID=0, FIFO_COUNT=0.
  - Both counters=0, OVERFLOW=0.
  - Pipeline stage empty, FIFO pointers=0.
  - Reset mid-frame or mid-pipeline discards everything in flight.
- Stage 1 (capture):
  - On PACKET_VALID=1, register PACKET_IN and set s1_valid.
  - Otherwise s1_valid=0.
  - No back-pressure: a strobe every cycle is accepted.
- Stage 2 (check), when s1_valid:
  - frame_err = (bit10 != 0) || (bit0 != 1).
  - par_err = !frame_err && (bit1 != (^data ^ PARITY_ODD)).
  - A frame with both defects counts as a frame error only.
  - good = !frame_err && !par_err.
  - frame_err → FRAME_ERR_CNT +1 (saturate at 255). par_err → PARITY_ERR_CNT +1 (saturate at 255).
  - Bad frames are never written to the FIFO.
  - good → push data to FIFO.
- Latency: PACKET_VALID in cycle N → DATA_VALID=1 with the byte on DATA_OUT in cycle N+2 (FIFO previously empty).
- FIFO:
  - FWFT: DATA_OUT always shows the head entry.
  - Pop when DATA_VALID && DATA_READY; DATA_READY is ignored when empty.
  - Push and pop in the same cycle: count unchanged.
  - If full, a same-cycle pop frees space and the push is accepted.
  - Push when full with no pop: byte dropped, OVERFLOW←1, count stays DEPTH.
  - Pointers wrap modulo DEPTH.
  - FIFO_COUNT is registered and reflects the cycle's push/pop after the clock edge.
- CLR_STATUS:
  - Zeros both counters and OVERFLOW next cycle.
  - Clear wins over a same-cycle increment or overflow event; that event is lost.
  - FIFO contents are unaffected.
- PACKET_IN is only sampled when PACKET_VALID=1; X on it otherwise must not propagate.

Test Plan:
- Good byte: reset, PACKET_IN=0x295 with one PACKET_VALID pulse, DATA_READY=1 → DATA_OUT=0xA5, DATA_VALID high 2 cycles after strobe for one cycle; counters remain 0.
- Parity error: PACKET_IN=0x297 → PARITY_ERR_CNT=1, FRAME_ERR_CNT=0, DATA_VALID stays 0.
- Frame error precedence: PACKET_IN=0x294 (stop=0), then 0x696 (start=1, parity also wrong) → FRAME_ERR_CNT=2, PARITY_ERR_CNT=0, FIFO empty.
- Fill and overflow (DATA_READY=0):
  - Push 0x001, 0x3FD, 0x295, 0x001 → FIFO_COUNT=4.
  - A 5th good frame → OVERFLOW=1, count 4.
  - Drain with DATA_READY=1 → 0x00, 0xFF, 0xA5, 0x00 in order.
- Full with simultaneous pop: FIFO full, good frame 0x3FD arriving in the same cycle as a pop → count stays 4, OVERFLOW stays 0, 0x3FD is the last byte drained.
- Saturation, clear and reset:
  - 300 frames of 0x297 → PARITY_ERR_CNT=255.
  - CLR_STATUS in the same cycle as another parity error → counter 0.
  - Assert UART_RST between strobe and output → DATA_VALID never rises; all outputs 0.
